// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control unit: opcodes, FSM states,
// operation classes and the wd_sel / alu_op encodings.
package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_NOP = 3'd0,
      C_ALU = 3'd1,
      C_LDI = 3'd2,
      C_LD  = 3'd3,
      C_ST  = 3'd4,
      C_JMP = 3'd5,
      C_JZ  = 3'd6,
      C_HLT = 3'd7
   } op_class_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_AND = 4'h3;
   localparam logic [3:0] OP_OR  = 4'h4;
   localparam logic [3:0] OP_XOR = 4'h5;
   localparam logic [3:0] OP_LDI = 4'h6;
   localparam logic [3:0] OP_LD  = 4'h7;
   localparam logic [3:0] OP_ST  = 4'h8;
   localparam logic [3:0] OP_JMP = 4'h9;
   localparam logic [3:0] OP_JZ  = 4'hA;
   localparam logic [3:0] OP_INC = 4'hB;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] WD_ALU = 2'd0;
   localparam logic [1:0] WD_IMM = 2'd1;
   localparam logic [1:0] WD_RAM = 2'd2;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_INC = 3'd5;

   // Highest register index that may be written
   localparam logic [2:0] MAX_REG = 3'd4;

endpackage

// File: rtl/cpu_instr_decoder.sv
// Combinational instruction decoder: splits an instruction word into fields
// and an operation class, folding illegal encodings into NOP.
module cpu_instr_decoder
   import cpu_pkg::*;
(
   input  logic [15:0] ir,
   output op_class_t   op_class,
   output logic [2:0]  alu_op,
   output logic [2:0]  rd,
   output logic [2:0]  rs1,
   output logic [2:0]  rs2,
   output logic [7:0]  imm,
   output logic        illegal
);

   op_class_t raw_class_s;
   logic      writes_s;
   logic      bad_op_s;

   assign rd  = ir[11:9];
   assign rs1 = ir[8:6];
   assign rs2 = ir[5:3];
   assign imm = ir[7:0];

   // Opcode lookup; register-writing ops are flagged for the rd range check
   always_comb begin
      raw_class_s = C_NOP;
      alu_op      = ALU_ADD;
      writes_s    = 1'b0;
      bad_op_s    = 1'b0;
      case (ir[15:12])
         OP_NOP: raw_class_s = C_NOP;
         OP_ADD: begin raw_class_s = C_ALU; alu_op = ALU_ADD; writes_s = 1'b1; end
         OP_SUB: begin raw_class_s = C_ALU; alu_op = ALU_SUB; writes_s = 1'b1; end
         OP_AND: begin raw_class_s = C_ALU; alu_op = ALU_AND; writes_s = 1'b1; end
         OP_OR:  begin raw_class_s = C_ALU; alu_op = ALU_OR;  writes_s = 1'b1; end
         OP_XOR: begin raw_class_s = C_ALU; alu_op = ALU_XOR; writes_s = 1'b1; end
         OP_INC: begin raw_class_s = C_ALU; alu_op = ALU_INC; writes_s = 1'b1; end
         OP_LDI: begin raw_class_s = C_LDI; writes_s = 1'b1; end
         OP_LD:  begin raw_class_s = C_LD;  writes_s = 1'b1; end
         OP_ST:  raw_class_s = C_ST;
         OP_JMP: raw_class_s = C_JMP;
         OP_JZ:  raw_class_s = C_JZ;
         OP_HLT: raw_class_s = C_HLT;
         default: bad_op_s = 1'b1;
      endcase
   end

   assign illegal  = bad_op_s || (writes_s && (rd > MAX_REG));
   assign op_class = illegal ? C_NOP : raw_class_s;

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer with
// all strobes registered so none of them depends combinationally on instr.
module cpu_control_unit
   import cpu_pkg::*;
#(
   parameter int unsigned     PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic [PC_W-1:0] pc,
   input  logic [15:0]     instr,
   input  logic            alu_zero,
   output logic            rf_we,
   output logic [2:0]      rf_wa,
   output logic [2:0]      rf_ra,
   output logic [2:0]      rf_rb,
   output logic [1:0]      wd_sel,
   output logic [2:0]      alu_op,
   output logic [7:0]      imm,
   output logic            mem_re,
   output logic            mem_we,
   output logic            halted,
   output logic            illegal
);

   state_t      state_r;
   logic [15:0] ir_r;
   logic        zero_r;

   logic [15:0] dec_ir_s;
   op_class_t   dec_class_s;
   logic [2:0]  dec_alu_op_s;
   logic [2:0]  dec_rd_s;
   logic [2:0]  dec_rs1_s;
   logic [2:0]  dec_rs2_s;
   logic [7:0]  dec_imm_s;
   logic        dec_illegal_s;

   // In DECODE the incoming word is decoded so EXEC strobes can be registered
   assign dec_ir_s = (state_r == S_DECODE) ? instr : ir_r;
   assign imm      = ir_r[7:0];

   cpu_instr_decoder u_dec (
      .ir       (dec_ir_s),
      .op_class (dec_class_s),
      .alu_op   (dec_alu_op_s),
      .rd       (dec_rd_s),
      .rs1      (dec_rs1_s),
      .rs2      (dec_rs2_s),
      .imm      (dec_imm_s),
      .illegal  (dec_illegal_s)
   );

   // Sequencer: state, PC, IR, zero flag and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_FETCH;
         pc      <= RESET_PC;
         ir_r    <= 16'h0000;
         zero_r  <= 1'b0;
         rf_we   <= 1'b0;
         rf_wa   <= 3'd0;
         rf_ra   <= 3'd0;
         rf_rb   <= 3'd0;
         wd_sel  <= WD_ALU;
         alu_op  <= ALU_ADD;
         mem_re  <= 1'b0;
         mem_we  <= 1'b0;
         halted  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         rf_we   <= 1'b0;
         mem_re  <= 1'b0;
         mem_we  <= 1'b0;
         illegal <= 1'b0;
         case (state_r)
            S_FETCH: state_r <= S_DECODE;
            S_DECODE: begin
               ir_r    <= instr;
               pc      <= pc + PC_W'(1);
               state_r <= S_EXEC;
               rf_wa   <= dec_rd_s;
               illegal <= dec_illegal_s;
               case (dec_class_s)
                  C_ALU: begin
                     rf_ra  <= dec_rs1_s;
                     rf_rb  <= dec_rs2_s;
                     alu_op <= dec_alu_op_s;
                  end
                  C_LD: mem_re <= 1'b1;
                  C_ST: begin
                     rf_ra  <= dec_rd_s;
                     mem_we <= 1'b1;
                  end
                  default: ;
               endcase
            end
            S_EXEC: begin
               case (dec_class_s)
                  C_ALU: begin
                     zero_r  <= alu_zero;
                     wd_sel  <= WD_ALU;
                     rf_we   <= 1'b1;
                     state_r <= S_WB;
                  end
                  C_LDI: begin
                     wd_sel  <= WD_IMM;
                     rf_we   <= 1'b1;
                     state_r <= S_WB;
                  end
                  C_LD: state_r <= S_MEM;
                  C_JMP: begin
                     pc      <= PC_W'(dec_imm_s);
                     state_r <= S_FETCH;
                  end
                  C_JZ: begin
                     if (zero_r) begin
                        pc <= PC_W'(dec_imm_s);
                     end
                     state_r <= S_FETCH;
                  end
                  C_HLT: begin
                     halted  <= 1'b1;
                     state_r <= S_HALT;
                  end
                  default: state_r <= S_FETCH;
               endcase
            end
            S_MEM: begin
               wd_sel  <= WD_RAM;
               rf_we   <= 1'b1;
               state_r <= S_WB;
            end
            S_WB:   state_r <= S_FETCH;
            S_HALT: begin
               halted  <= 1'b1;
               state_r <= S_HALT;
            end
            default: state_r <= S_FETCH;
         endcase
      end
   end

endmodule
